// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel path.
package vga_pkg;

    localparam logic [7:0] X_MAX_DEF = 8'd160;
    localparam logic [7:0] Y_MAX_DEF = 8'd120;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] GREEN  = 3'b010;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    typedef enum logic {
        SRC_BIRD = 1'b0,
        SRC_PIPE = 1'b1
    } src_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] colour;
    } pixel_t;

    // Full 8-bit compare so out-of-range rows are dropped, not wrapped.
    function automatic logic on_screen(input pixel_t p, input logic [7:0] xmax,
                                       input logic [7:0] ymax);
        return (p.x < xmax) && (p.y < ymax);
    endfunction

endpackage

// File: rtl/plot_rr_arbiter.sv
// Two-source round-robin grant; ties go to the source not granted last.
module plot_rr_arbiter
    import vga_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic [1:0] i_req,     // [0] bird, [1] pipe
    output logic [1:0] o_grant
);

    src_t       r_last;
    logic [1:0] w_grant;

    // Grant is only issued when requested and enabled, so a grant is a handshake.
    always_comb begin
        w_grant = 2'b00;
        if (i_en) begin
            if (&i_req)
                w_grant = (r_last == SRC_PIPE) ? 2'b01 : 2'b10;
            else
                w_grant = i_req;
        end
    end

    assign o_grant = w_grant;

    // Remember who was served last; reset favours bird on the first tie.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_last <= SRC_PIPE;
        else if (|w_grant)
            r_last <= w_grant[1] ? SRC_PIPE : SRC_BIRD;
    end

endmodule

// File: rtl/pixel_plot_mux.sv
// Merges bird/pipe pixel streams into the VGA write port, clips off-screen
// pixels and runs the full-screen clear sweep.
module pixel_plot_mux
    import vga_pkg::*;
#(
    parameter logic [7:0] X_MAX        = X_MAX_DEF,
    parameter logic [7:0] Y_MAX        = Y_MAX_DEF,
    parameter logic [2:0] CLEAR_COLOUR = BLACK
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_bird_valid,
    input  logic [7:0] i_bird_x,
    input  logic [7:0] i_bird_y,
    input  logic [2:0] i_bird_colour,
    output logic       o_bird_ready,
    input  logic       i_pipe_valid,
    input  logic [7:0] i_pipe_x,
    input  logic [7:0] i_pipe_y,
    input  logic [2:0] i_pipe_colour,
    output logic       o_pipe_ready,
    input  logic       i_clear_req,
    output logic       o_clear_busy,
    output logic [7:0] o_vga_x,
    output logic [6:0] o_vga_y,
    output logic [2:0] o_vga_colour,
    output logic       o_vga_plot
);

    localparam logic [7:0] X_LAST = X_MAX - 8'd1;
    localparam logic [6:0] Y_LAST = 7'(Y_MAX - 8'd1);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cx;
    logic [6:0] r_cy;
    logic [7:0] r_vga_x;
    logic [6:0] r_vga_y;
    logic [2:0] r_vga_colour;
    logic       r_vga_plot;

    logic       w_en;
    logic [1:0] w_grant;
    logic       w_sweep_last;
    pixel_t     w_bird, w_pipe, w_pix;

    assign w_en = (r_state == ST_IDLE) && !i_clear_req && !i_reset;

    plot_rr_arbiter u_arb (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (w_en),
        .i_req   ({i_pipe_valid, i_bird_valid}),
        .o_grant (w_grant)
    );

    assign o_bird_ready = w_grant[0];
    assign o_pipe_ready = w_grant[1];

    assign w_bird       = '{x: i_bird_x, y: i_bird_y, colour: i_bird_colour};
    assign w_pipe       = '{x: i_pipe_x, y: i_pipe_y, colour: i_pipe_colour};
    assign w_pix        = w_grant[1] ? w_pipe : w_bird;
    assign w_sweep_last = (r_cx == X_LAST) && (r_cy == Y_LAST);

    // Next-state: clear request starts the sweep, last sweep pixel ends it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_clear_req)  w_state_nxt = ST_SWEEP;
            ST_SWEEP: if (w_sweep_last) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Sweep counters walk rows left to right, wrapping back to (0,0) at the end.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (r_state == ST_SWEEP) begin
            if (r_cx == X_LAST) begin
                r_cx <= '0;
                r_cy <= (r_cy == Y_LAST) ? 7'd0 : r_cy + 7'd1;
            end else begin
                r_cx <= r_cx + 8'd1;
            end
        end else if (i_clear_req) begin
            r_cx <= '0;
            r_cy <= '0;
        end
    end

    // Output register: sweep pixel, accepted on-screen pixel, or no plot (hold coords).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else if (r_state == ST_SWEEP) begin
            r_vga_x      <= r_cx;
            r_vga_y      <= r_cy;
            r_vga_colour <= CLEAR_COLOUR;
            r_vga_plot   <= 1'b1;
        end else if ((|w_grant) && on_screen(w_pix, X_MAX, Y_MAX)) begin
            r_vga_x      <= w_pix.x;
            r_vga_y      <= w_pix.y[6:0];
            r_vga_colour <= w_pix.colour;
            r_vga_plot   <= 1'b1;
        end else begin
            r_vga_plot   <= 1'b0;
        end
    end

    assign o_clear_busy = (r_state == ST_SWEEP);
    assign o_vga_x      = r_vga_x;
    assign o_vga_y      = r_vga_y;
    assign o_vga_colour = r_vga_colour;
    assign o_vga_plot   = r_vga_plot;

endmodule

// File: tb/tb_pixel_plot_mux.sv
// Directed and random stimulus for pixel_plot_mux against a behavioural model.
module tb_pixel_plot_mux;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bird_valid = 1'b0, pipe_valid = 1'b0, clear_req = 1'b0;
    logic [7:0] bird_x = '0, bird_y = '0, pipe_x = '0, pipe_y = '0;
    logic [2:0] bird_colour = '0, pipe_colour = '0;
    logic       bird_ready, pipe_ready, clear_busy, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int checks = 0;
    int errors = 0;

    // model state
    bit m_busy      = 1'b0;
    int m_k         = 0;     // index of next sweep pixel, row-major
    bit m_last_pipe = 1'b1;
    int m_plot = 0, m_x = 0, m_y = 0, m_c = 0;

    always #5 clk = ~clk;

    pixel_plot_mux dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_bird_valid (bird_valid),
        .i_bird_x     (bird_x),
        .i_bird_y     (bird_y),
        .i_bird_colour(bird_colour),
        .o_bird_ready (bird_ready),
        .i_pipe_valid (pipe_valid),
        .i_pipe_x     (pipe_x),
        .i_pipe_y     (pipe_y),
        .i_pipe_colour(pipe_colour),
        .o_pipe_ready (pipe_ready),
        .i_clear_req  (clear_req),
        .o_clear_busy (clear_busy),
        .o_vga_x      (vga_x),
        .o_vga_y      (vga_y),
        .o_vga_colour (vga_colour),
        .o_vga_plot   (vga_plot)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check readies, then check registered outputs after posedge.
    task automatic step(input bit rst, input bit clr,
                        input bit bv, input int bx, input int by, input int bc,
                        input bit pv, input int px, input int py, input int pc);
        bit gb, gp, en;
        int sx, sy, sc;
        @(negedge clk);
        reset = rst; clear_req = clr;
        bird_valid = bv; bird_x = 8'(bx); bird_y = 8'(by); bird_colour = 3'(bc);
        pipe_valid = pv; pipe_x = 8'(px); pipe_y = 8'(py); pipe_colour = 3'(pc);
        #1;
        en = !m_busy && !clr && !rst;
        gb = 1'b0; gp = 1'b0;
        if (en) begin
            if (bv && pv) begin
                if (m_last_pipe) gb = 1'b1; else gp = 1'b1;
            end else begin
                gb = bv; gp = pv;
            end
        end
        chk("bird_ready", 32'(bird_ready), 32'(gb));
        chk("pipe_ready", 32'(pipe_ready), 32'(gp));
        chk("busy_pre", 32'(clear_busy), 32'(m_busy));

        if (rst) begin
            m_busy = 1'b0; m_k = 0; m_last_pipe = 1'b1;
            m_plot = 0; m_x = 0; m_y = 0; m_c = 0;
        end else if (m_busy) begin
            m_plot = 1; m_x = m_k % 160; m_y = m_k / 160; m_c = 0;
            m_k++;
            if (m_k == 160 * 120) m_busy = 1'b0;
        end else if (clr) begin
            m_busy = 1'b1; m_k = 0; m_plot = 0;
        end else if (gb || gp) begin
            m_last_pipe = gp;
            sx = gp ? px : bx; sy = gp ? py : by; sc = gp ? pc : bc;
            if (sx < 160 && sy < 120) begin
                m_plot = 1; m_x = sx; m_y = sy; m_c = sc;
            end else begin
                m_plot = 0;
            end
        end else begin
            m_plot = 0;
        end

        @(posedge clk);
        #1;
        chk("vga_plot", 32'(vga_plot), m_plot);
        chk("vga_x", 32'(vga_x), m_x);
        chk("vga_y", 32'(vga_y), m_y);
        chk("vga_colour", 32'(vga_colour), m_c);
        chk("busy_post", 32'(clear_busy), 32'(m_busy));
    endtask

    task automatic rnd_step(input bit rst, input bit clr);
        step(rst, clr,
             1'($urandom_range(0, 1)), $urandom_range(0, 200), $urandom_range(0, 140), $urandom_range(0, 7),
             1'($urandom_range(0, 1)), $urandom_range(0, 200), $urandom_range(0, 140), $urandom_range(0, 7));
    endtask

    initial begin
        // reset with sources valid: readies must stay low
        step(1, 0, 1, 5, 5, 1, 1, 6, 6, 2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // bird only
        step(0, 0, 1, 24, 48, 6, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // contention from reset: bird, pipe, bird, pipe
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(0, 0, 1, 10 + i, 20 + i, 3'b110, 1, 100 + i, 50 + i, 3'b010);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // clipping boundaries
        step(0, 0, 1, 160, 10, 5, 0, 0, 0, 0);
        step(0, 0, 1, 10, 120, 5, 0, 0, 0, 0);
        step(0, 0, 1, 159, 119, 5, 0, 0, 0, 0);
        step(0, 0, 1, 255, 255, 7, 1, 0, 0, 1);

        // random arbitration traffic
        for (int i = 0; i < 200; i++) rnd_step(0, 0);

        // full clear with both sources pending; re-request at pixel 500 is ignored
        step(0, 1, 1, 1, 1, 1, 1, 2, 2, 2);
        for (int i = 0; i < 160 * 120 + 4; i++)
            rnd_step(0, m_busy && (m_k == 500));

        // second clear, reset at sweep pixel 1000
        step(0, 1, 1, 1, 1, 1, 1, 2, 2, 2);
        for (int i = 0; i < 1000; i++) rnd_step(0, 0);
        rnd_step(1, 0);
        step(0, 0, 1, 30, 40, 3'b110, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) rnd_step(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
